// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned WordShift    = 2;
  localparam int unsigned ByteIdxW     = $clog2(BytesPerWord);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StCheck,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words.
// word_o already includes the byte accepted this cycle, so a caller can capture
// the full word on the same edge as the last byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_byte_o
);

  logic [ByteIdxW-1:0] idx_q, idx_d;
  logic [31:0]         word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + ByteIdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_d;
  assign last_byte_o = accept_i && (idx_q == ByteIdxW'(BytesPerWord - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program image into the instruction memory write port.
// Optional trailing checksum word: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MemDepth = 1024,
  parameter logic [31:0] BaseAddr = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] num_words_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] word_count_o
);

  state_e      state_q, state_d;
  logic [31:0] num_words_q;
  logic [31:0] word_idx_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic [31:0] last_idx;
  logic [31:0] asm_word;
  logic        accept;
  logic        last_byte;
  logic        load;
  logic        start_ok;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  assign start_ok = (num_words_i != 32'd0) && (num_words_i <= MemDepth);
  assign last_idx = num_words_q - 32'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready_o = (state_q == StCollect) || (state_q == StCheck);
`else
  assign byte_ready_o = (state_q == StCollect);
`endif

  assign accept = byte_valid_i && byte_ready_o;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          if (start_ok) begin
            state_d = StCollect;
            load    = 1'b1;
          end else begin
            state_d = StErr;
          end
        end
      end
      StCollect: begin
        if (last_byte) state_d = StWrite;
      end
      StWrite: begin
        if (word_idx_q == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StCollect;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (last_byte) state_d = (asm_word == sum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      num_words_q <= '0;
      word_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        num_words_q <= num_words_i;
        word_idx_q  <= '0;
      end else if (state_q == StWrite) begin
        word_idx_q <= word_idx_q + 32'd1;
      end
      // Capture on the 4th byte so the write port is valid throughout WRITE.
      if ((state_q == StCollect) && last_byte) begin
        mem_addr_q <= BaseAddr + (word_idx_q << WordShift);
        mem_din_q  <= asm_word;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (load) begin
      sum_q <= '0;
    end else if (state_q == StWrite) begin
      sum_q <= sum_q + mem_din_q;
    end
  end
`endif

  imem_word_assembler u_assembler (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (load),
    .accept_i    (accept),
    .byte_i      (byte_data_i),
    .word_o      (asm_word),
    .last_byte_o (last_byte)
  );

  assign mem_we_o     = (state_q == StWrite);
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;
  assign busy_o       = (state_q == StCollect) || (state_q == StWrite) || (state_q == StCheck);
  assign done_o       = (state_q == StDone);
  assign error_o      = (state_q == StErr);
  assign word_count_o = word_idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-list reference model.
module tb_imem_loader;

  localparam int unsigned MemDepth = 1024;
  localparam logic [31:0] BaseAddr = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] word_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  tx_q[$];
  logic [63:0] obs_q[$];

  imem_loader #(
    .MemDepth (MemDepth),
    .BaseAddr (BaseAddr)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .num_words_i  (num_words),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_din_o    (mem_din),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .word_count_o (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write cycle once, shortly after the edge that opened it.
  always @(posedge clk) begin
    #1;
    if (mem_we) obs_q.push_back({mem_addr, mem_din});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge with byte_valid low.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int budget;
    repeat (gap) begin
      start     = noise ? 1'($urandom) : 1'b0;
      num_words = $urandom;
      @(negedge clk);
    end
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    budget     = 0;
    while (!byte_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic do_start(input logic [31:0] n);
    @(negedge clk);
    num_words = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    num_words = $urandom;
  endtask

  // Loads n words from tx_q and compares writes/status with the model.
  task automatic run_load(input logic [31:0] n, input int gap_max, input bit gap_rand,
                          input bit noise, input bit bad_sum);
    logic [63:0] exp_q[$];
    logic [31:0] w;
    logic [31:0] sum;
    logic [31:0] ck;
    bit          exp_err;
    int          gap;
    obs_q.delete();
    do_start(n);
    check("start_done_clr", 32'(done), 32'd0);
    if (n == 0 || n > MemDepth) begin
      check("bound_err", 32'(error), 32'd1);
      check("bound_busy", 32'(busy), 32'd0);
      check("bound_rdy", 32'(byte_ready), 32'd0);
      byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      check("bound_nowr", 32'(obs_q.size()), 32'd0);
      check("bound_err_hold", 32'(error), 32'd1);
      return;
    end
    check("start_err", 32'(error), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cnt", word_count, 32'd0);
    sum = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      w = {tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1], tx_q[4*i]};
      exp_q.push_back({BaseAddr + 32'(4 * i), w});
      sum = sum + w;
    end
    for (int i = 0; i < 4 * int'(n); i++) begin
      gap = gap_rand ? int'($urandom_range(0, gap_max)) : gap_max;
      if (i % 4 == 3) check("early_we", 32'(obs_q.size()), 32'(i / 4));
      send_byte(tx_q[i], gap, noise);
      if (i % 4 == 3) begin
        check("we_latency", 32'(mem_we), 32'd1);
        check("we_addr", mem_addr, BaseAddr + 32'(4 * (i / 4)));
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck = bad_sum ? sum + 32'd1 : sum;
    for (int k = 0; k < 4; k++) send_byte(ck[8*k +: 8], gap_max, 1'b0);
    exp_err = bad_sum;
`else
    ck      = sum;
    exp_err = 1'b0;
`endif
    @(negedge clk);
    check("nwrites", 32'(obs_q.size()), n);
    for (int i = 0; i < int'(n) && i < obs_q.size(); i++) begin
      check("wr_addr", obs_q[i][63:32], exp_q[i][63:32]);
      check("wr_data", obs_q[i][31:0], exp_q[i][31:0]);
    end
    check("end_done", 32'(done), 32'(!exp_err));
    check("end_err", 32'(error), 32'(exp_err));
    check("end_busy", 32'(busy), 32'd0);
    check("end_cnt", word_count, n);
    check("end_we", 32'(mem_we), 32'd0);
  endtask

  task automatic fill_tx(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    #1;
    check("rst_rdy", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_din", mem_din, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_cnt", word_count, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two-word load, back-to-back bytes, then with 3-cycle gaps.
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(32'd2, 0, 1'b0, 1'b0, 1'b0);
    run_load(32'd2, 3, 1'b0, 1'b0, 1'b0);

    // Bytes offered in DONE are refused; then restart from DONE.
    check("done_hold", 32'(done), 32'd1);
    obs_q.delete();
    byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    check("done_rdy", 32'(byte_ready), 32'd0);
    check("done_nowr", 32'(obs_q.size()), 32'd0);
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_load(32'd1, 0, 1'b0, 1'b0, 1'b0);

    // Bounds.
    run_load(32'd0, 0, 1'b0, 1'b0, 1'b0);
    run_load(32'd1025, 0, 1'b0, 1'b0, 1'b0);
    run_load(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the second word.
    fill_tx(8);
    obs_q.delete();
    do_start(32'd2);
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdy", 32'(byte_ready), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_din", mem_din, 32'd0);
    check("mid_rst_cnt", word_count, 32'd0);
    check("mid_rst_nwr", 32'(obs_q.size()), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({busy, done, error}), 32'd0);
    fill_tx(4);
    run_load(32'd1, 1, 1'b1, 1'b0, 1'b0);

    // Full memory depth.
    fill_tx(4 * MemDepth);
    run_load(32'(MemDepth), 0, 1'b0, 1'b0, 1'b0);

    // Random loads with gaps and ignored start/num_words noise.
    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(1, 6));
      fill_tx(4 * n);
      run_load(32'(n), 3, 1'b1, 1'b1, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(32'd2, 0, 1'b0, 1'b0, 1'b0);
    run_load(32'd2, 0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 4));
      fill_tx(4 * n);
      run_load(32'(n), 2, 1'b1, 1'b1, 1'(r % 2));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
